// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder with posted-write buffer, load forwarding
//             and a small MMIO block (LED register, 32-bit cycle counter).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int RAM_AW   = 12,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [15:0] led_out
);

  localparam int              c_pw        = $clog2(WB_DEPTH);
  localparam int              c_cw        = c_pw + 1;
  localparam logic [c_cw-1:0] c_full      = c_cw'(WB_DEPTH);
  localparam logic [15:0]     c_mmio_base = 16'hFF00;
  localparam logic [15:0]     c_led_addr  = 16'hFFF0;
  localparam logic [15:0]     c_cnt_lo    = 16'hFFF1;
  localparam logic [15:0]     c_cnt_hi    = 16'hFFF2;

  logic [15:0]       r_mem     [0:(1<<RAM_AW)-1];
  logic [RAM_AW-1:0] r_wb_addr [0:WB_DEPTH-1];
  logic [15:0]       r_wb_data [0:WB_DEPTH-1];
  logic [c_pw-1:0]   r_head;
  logic [c_pw-1:0]   r_tail;
  logic [c_cw-1:0]   r_count;
  logic [31:0]       r_cycle;
  logic [15:0]       r_snap;

  logic              w_is_mmio;
  logic [RAM_AW-1:0] w_idx;
  logic              w_accept;
  logic              w_ram_store;
  logic              w_ram_load;
  logic              w_mmio_store;
  logic              w_mmio_load;
  logic              w_drain;
  logic              w_fwd_hit;
  logic [15:0]       w_fwd_data;
  logic [c_pw-1:0]   w_slot;
  logic [15:0]       w_mmio_rdata;

  assign w_is_mmio    = (req_addr >= c_mmio_base);
  assign w_idx        = req_addr[RAM_AW-1:0];
  assign req_ready    = !(req_valid && req_we && !w_is_mmio && (r_count == c_full));
  assign w_accept     = req_valid && req_ready;
  assign w_ram_store  = w_accept &&  req_we && !w_is_mmio;
  assign w_ram_load   = w_accept && !req_we && !w_is_mmio;
  assign w_mmio_store = w_accept &&  req_we &&  w_is_mmio;
  assign w_mmio_load  = w_accept && !req_we &&  w_is_mmio;
  // A RAM load owns the single RAM port; otherwise the oldest entry retires.
  assign w_drain      = !w_ram_load && (r_count != '0);

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_slot     = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_slot = r_head + c_pw'(k);
      if ((c_cw'(k) < r_count) && (r_wb_addr[w_slot] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[w_slot];
      end
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    case (req_addr)
      c_led_addr: w_mmio_rdata = led_out;
      c_cnt_lo:   w_mmio_rdata = r_cycle[15:0];
      c_cnt_hi:   w_mmio_rdata = r_snap;
      default:    w_mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      led_out    <= '0;
      r_cycle    <= '0;
      r_snap     <= '0;
    end else begin
      r_cycle    <= r_cycle + 32'd1;
      resp_valid <= w_ram_load || w_mmio_load;
      if (w_ram_load)
        resp_rdata <= w_fwd_hit ? w_fwd_data : r_mem[w_idx];
      else if (w_mmio_load)
        resp_rdata <= w_mmio_rdata;
      // Reading the low half freezes the high half for a coherent 32-bit pair.
      if (w_mmio_load && (req_addr == c_cnt_lo))
        r_snap <= r_cycle[31:16];
      if (w_mmio_store && (req_addr == c_led_addr))
        led_out <= req_wdata;
      if (w_ram_store)
        r_tail <= r_tail + c_pw'(1);
      if (w_drain)
        r_head <= r_head + c_pw'(1);
      case ({w_ram_store, w_drain})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid window is defined by head/count.
  always_ff @(posedge clk) begin
    if (w_ram_store) begin
      r_wb_addr[r_tail] <= w_idx;
      r_wb_data[r_tail] <= req_wdata;
    end
    if (w_drain)
      r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench: directed vector table, FIFO/RAM reference
//             model under random traffic, and reset/counter sequences.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int AW = 12;
  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] led_out;

  dmem_responder #(.RAM_AW(AW), .WB_DEPTH(WB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: cycles elapsed since reset release.
  logic [31:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + 32'd1;
  end

  typedef struct {
    logic [11:0] idx;
    logic [15:0] data;
  } wb_t;

  logic [15:0] ram_sh [0:4095];
  bit          ram_kn [0:4095];
  wb_t         q[$];
  logic [15:0] led_m, snap_m, last_rd;
  bit          last_kn;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rdy;
    logic        rv;
    logic [15:0] rd;
    logic [15:0] led;
  } vec_t;

  function automatic vec_t mk(input logic v, we, input logic [15:0] a, d,
                              input logic rdy, rv, input logic [15:0] rd, led);
    vec_t t;
    t.v = v; t.we = we; t.addr = a; t.wdata = d;
    t.rdy = rdy; t.rv = rv; t.rd = rd; t.led = led;
    return t;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic v, we, input logic [15:0] a, d,
                       output logic rdy, rv, output logic [15:0] rd, ld);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    #1 rdy = req_ready;
    @(posedge clk);
    @(negedge clk);
    rv = resp_valid; rd = resp_rdata; ld = led_out;
  endtask

  task automatic mstep(input string tag, input logic v, we, input logic [15:0] a, d);
    logic        mm, e_rdy, acc, ld, rdy, rv;
    logic [11:0] ix;
    logic [15:0] ed, rd, lo;
    bit          kn;
    wb_t         e;
    mm    = (a >= 16'hFF00);
    ix    = a[11:0];
    e_rdy = !(v && we && !mm && (q.size() == WB));
    acc   = v && e_rdy;
    ld    = acc && !we;
    kn    = 1;
    ed    = last_rd;
    kn    = last_kn;
    if (ld) begin
      kn = 1;
      if (mm) begin
        case (a)
          16'hFFF0: ed = led_m;
          16'hFFF1: ed = m_cnt[15:0];
          16'hFFF2: ed = snap_m;
          default:  ed = 16'h0000;
        endcase
      end else begin
        ed = ram_sh[ix];
        kn = ram_kn[ix];
        for (int k = 0; k < q.size(); k++)
          if (q[k].idx == ix) begin ed = q[k].data; kn = 1; end
      end
    end
    if (ld && a == 16'hFFF1) snap_m = m_cnt[31:16];
    if (!(ld && !mm) && q.size() > 0) begin
      ram_sh[q[0].idx] = q[0].data;
      ram_kn[q[0].idx] = 1;
      void'(q.pop_front());
    end
    if (acc && we && !mm) begin e.idx = ix; e.data = d; q.push_back(e); end
    if (acc && we && a == 16'hFFF0) led_m = d;
    cycle(v, we, a, d, rdy, rv, rd, lo);
    chk({tag, ".ready"}, {31'd0, rdy}, {31'd0, e_rdy});
    chk({tag, ".rvalid"}, {31'd0, rv}, {31'd0, ld});
    if (kn) chk({tag, ".rdata"}, {16'd0, rd}, {16'd0, ed});
    chk({tag, ".led"}, {16'd0, lo}, {16'd0, led_m});
    last_rd = ed;
    last_kn = kn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  vec_t        tbl [18];
  logic [15:0] mlist [5];
  logic        o_rdy, o_rv;
  logic [15:0] o_rd, o_ld, a, d;
  int          r;

  initial begin
    tbl[0]  = mk(1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0010, 16'h0000, 1, 1, 16'hBEEF, 16'h0000);
    tbl[2]  = mk(1, 1, 16'h0020, 16'h1111, 1, 0, 16'hBEEF, 16'h0000);
    tbl[3]  = mk(1, 1, 16'h0020, 16'h2222, 1, 0, 16'hBEEF, 16'h0000);
    tbl[4]  = mk(1, 0, 16'h0020, 16'h0000, 1, 1, 16'h2222, 16'h0000);
    tbl[5]  = mk(1, 0, 16'h0010, 16'h0000, 1, 1, 16'hBEEF, 16'h0000);
    tbl[6]  = mk(1, 1, 16'hFFF0, 16'h00A5, 1, 0, 16'hBEEF, 16'h00A5);
    tbl[7]  = mk(1, 0, 16'hFFF0, 16'h0000, 1, 1, 16'h00A5, 16'h00A5);
    tbl[8]  = mk(1, 0, 16'hFF80, 16'h0000, 1, 1, 16'h0000, 16'h00A5);
    tbl[9]  = mk(1, 0, 16'h0020, 16'h0000, 1, 1, 16'h2222, 16'h00A5);
    tbl[10] = mk(1, 1, 16'hFFF1, 16'h1234, 1, 0, 16'h2222, 16'h00A5);
    tbl[11] = mk(1, 1, 16'hFF80, 16'h5555, 1, 0, 16'h2222, 16'h00A5);
    tbl[12] = mk(1, 0, 16'hFF80, 16'h0000, 1, 1, 16'h0000, 16'h00A5);
    tbl[13] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h00A5);
    tbl[14] = mk(1, 0, 16'h1010, 16'h0000, 1, 1, 16'hBEEF, 16'h00A5);
    tbl[15] = mk(1, 1, 16'h2020, 16'h3333, 1, 0, 16'hBEEF, 16'h00A5);
    tbl[16] = mk(1, 0, 16'h0020, 16'h0000, 1, 1, 16'h3333, 16'h00A5);
    tbl[17] = mk(1, 0, 16'hFFF2, 16'h0000, 1, 1, 16'h0000, 16'h00A5);
    mlist[0] = 16'hFFF0; mlist[1] = 16'hFFF1; mlist[2] = 16'hFFF2;
    mlist[3] = 16'hFF80; mlist[4] = 16'hFFFF;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("reset.ready", {31'd0, req_ready}, 32'd1);
    chk("reset.rvalid", {31'd0, resp_valid}, 32'd0);
    chk("reset.rdata", {16'd0, resp_rdata}, 32'd0);
    chk("reset.led", {16'd0, led_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wdata, o_rdy, o_rv, o_rd, o_ld);
      chk($sformatf("vec%0d.ready", i), {31'd0, o_rdy}, {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d.rvalid", i), {31'd0, o_rv}, {31'd0, tbl[i].rv});
      chk($sformatf("vec%0d.rdata", i), {16'd0, o_rd}, {16'd0, tbl[i].rd});
      chk($sformatf("vec%0d.led", i), {16'd0, o_ld}, {16'd0, tbl[i].led});
    end
    repeat (2) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, o_rdy, o_rv, o_rd, o_ld);

    // Model picks up the state the vector table left behind.
    q.delete();
    for (int i = 0; i < 4096; i++) ram_kn[i] = 0;
    ram_sh[12'h010] = 16'hBEEF; ram_kn[12'h010] = 1;
    ram_sh[12'h020] = 16'h3333; ram_kn[12'h020] = 1;
    led_m = 16'h00A5; snap_m = 16'h0000; last_rd = 16'h0000; last_kn = 1;

    for (int i = 0; i < 16; i++) mstep("seed", 1'b1, 1'b1, 16'(i), 16'($urandom));

    // Back-to-back stores with draining blocked by interleaved loads.
    for (int i = 0; i < 5; i++) begin
      mstep("full.st", 1'b1, 1'b1, 16'h0100 + 16'(i), 16'hC000 + 16'(i));
      mstep("full.ld", 1'b1, 1'b0, 16'h0010, 16'h0000);
    end
    for (int i = 0; i < 5; i++) mstep("full.rb", 1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0000);

    // Coherent 32-bit counter read.
    mstep("cnt.lo", 1'b1, 1'b0, 16'hFFF1, 16'h0000);
    repeat (3) mstep("cnt.idle", 1'b0, 1'b0, 16'h0000, 16'h0000);
    mstep("cnt.hi", 1'b1, 1'b0, 16'hFFF2, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) a = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom_range(0, 15))};
      else        a = mlist[$urandom_range(0, 4)];
      d = 16'($urandom);
      mstep("rand", 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), a, d);
    end

    // Asynchronous reset with a store still buffered.
    mstep("rst.st0", 1'b1, 1'b1, 16'h0000, 16'hD000);
    mstep("rst.st1", 1'b1, 1'b1, 16'h0001, 16'hD001);
    mstep("rst.st2", 1'b1, 1'b1, 16'h0002, 16'hD002);
    mstep("rst.ld5", 1'b1, 1'b0, 16'h0005, 16'h0000);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst.rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst.rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst.led", {16'd0, led_out}, 32'd0);
    q.delete();
    led_m = 16'h0000; snap_m = 16'h0000; last_rd = 16'h0000; last_kn = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mstep("post.ld0", 1'b1, 1'b0, 16'h0000, 16'h0000);
    mstep("post.ld1", 1'b1, 1'b0, 16'h0001, 16'h0000);
    mstep("post.ld2", 1'b1, 1'b0, 16'h0002, 16'h0000);
    mstep("post.led", 1'b1, 1'b0, 16'hFFF0, 16'h0000);
    mstep("post.cnt", 1'b1, 1'b0, 16'hFFF1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
